alu_resp_decoder: RTL and testbench
===================================

# alu_resp_decoder

- Serial-side responder monitor for the ALU.
- Deserializes the ALU's `sout` response stream into either:
  - a 32-bit result with its flags and CRC status, or
  - a decoded error packet.
- Sits between the ALU serial output and the bench scoreboard/coverage, mirroring the BFM's packet sender on the input side.
- Reports framing violations and inter-packet timeouts, so corrupted responses are flagged rather than silently merged.

## Interface
- `TIMEOUT_CYCLES`, 64: maximum idle cycles allowed between packets of one response before abort.
- `clk`  in  1  system clock; one serial bit per cycle.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sout`  in  1  ALU serial output; idles high.
- `res_valid`  out  1  one-cycle pulse: a complete result response was decoded.
- `result`  out  32  C, MSB byte first on the line.
- `flags`  out  4  {carry, overflow, zero, negative}.
- `crc_ok`  out  1  received CRC3 matches the computed CRC3.
- `err_valid`  out  1  one-cycle pulse: an error packet was decoded.
- `err_flags`  out  6  {ERR_DATA, ERR_CRC, ERR_OP, ERR_DATA, ERR_CRC, ERR_OP}, as sent.
- `parity_ok`  out  1  error-packet parity is correct.
- `frame_err`  out  1  one-cycle pulse: bad stop bit, sequence violation, or timeout.

## Operation
- **Packet format**, 11 bits, MSB first:
  - start bit 0
  - type bit: 0 = DATA, 1 = CTL
  - 8 payload bits
  - stop bit 1
- **Result response:** 4 DATA packets (C[31:24] down to C[7:0]), then one CTL packet with payload {0, flags[3:0], crc[2:0]}.
- **CRC3:** polynomial x^3+x+1, init 0, computed over the 37-bit vector {C, 1'b0, flags} MSB first.
- **Error response:** one CTL packet alone, payload {1, err_flags[5:0], parity}.
  - parity = XOR of payload bits [7:1] (even parity over the full byte).
- **Packet FSM:**
  - PK_IDLE → PK_SHIFT when `sout`==0.
  - PK_SHIFT samples 10 bits, counter 9..0.
  - PK_CHECK (1 cycle) validates the stop bit, then returns to PK_IDLE.
- **Response FSM:**
  - R_WAIT: data count 0.
  - R_DATA: 1..4 DATA packets held.
  - R_EMIT: one cycle, drives the pulses.
- **Sequence rules** (each violation pulses `frame_err` and discards the response):
  - DATA packet when count==4.
  - CTL payload[7]==0 with count≠4.
  - CTL payload[7]==1 with count≠0.
  - Stop bit 0.
- **Timeout:** in R_DATA, more than `TIMEOUT_CYCLES` consecutive idle cycles (measured stop bit to next start bit) → `frame_err`, return to R_WAIT.
- **Output holding:** `result`, `flags`, `crc_ok`, `err_flags` and `parity_ok` hold their last decoded values until the next decode.
- **Exclusivity:** `res_valid`, `err_valid` and `frame_err` are mutually exclusive.

## Timing
- Start bit sampled in cycle S. Payload and type bits arrive in S+1..S+9; the stop bit arrives in S+10.
- PK_CHECK occurs in S+11.
- Pulse latency: `res_valid`/`err_valid`/`frame_err` go high in S+12, where S is the last packet's start cycle, and last exactly one cycle.
- Back-to-back packets: a new start bit is accepted from S+11 onward (zero-gap packets supported). A start bit in the PK_CHECK cycle is captured.
- **Reset values:** all outputs 0; `result`=32'h0; `crc_ok`=0; `parity_ok`=0; both FSMs idle; counters 0.
- **Reset mid-packet or mid-response:** the async assert clears everything immediately, and no pulse is emitted for the partial response.
- **Bus contention:** `sout` stuck low after a framing error restarts a packet each time a 0 is seen in PK_IDLE.

## Configuration
- **`ALU_RESP_CRC_CHECK_EN` defined:** the CRC3 calculator is instantiated and `crc_ok` reflects the comparison.
- **Not defined:** there is no CRC logic and `crc_ok` is driven 1 whenever `res_valid` pulses (reset value still 0).
- Parity checking is always present.

## Structure
- **Added to `alu_pkg`:**
  - `pkt_type_t` (DATA, CTL)
  - `resp_state_t`
  - `ERR_*` bit-index constants
  - `function calc_crc3(bit [36:0])`, shared with the scoreboard
- **Sub-module `alu_pkt_rx`:** 11-bit packet deserializer (PK_* FSM). Outputs `pkt_valid`, `pkt_type`, `pkt_byte[7:0]` and `pkt_stop_err`.
- The top level holds the response FSM, the byte assembly and the timeout counter.

## Test plan
- **Result response:** C=32'h1234_5678, flags=4'b0000, correct CRC3, packets back-to-back → `res_valid` once at S+12, `result`=32'h1234_5678, `crc_ok`=1.
- **CRC corruption:** same packets with the CRC field XOR 3'b001 → `res_valid`, `crc_ok`=0 (with macro); `crc_ok`=1 (without macro).
- **Error packet:** single CTL packet, payload 8'hC9 → `err_valid`, `err_flags`=6'b100100, `parity_ok`=1. Payload 8'hC8 → `parity_ok`=0.
- **Framing and sequence errors:**
  - Stop bit 0 in the second DATA packet → `frame_err` pulse.
  - CTL after 3 DATA packets → `frame_err`.
  - Neither case raises `res_valid`.
- **Timeout:** 2 DATA packets, then idle for 65 cycles → `frame_err`. A following valid 5-packet response decodes normally.
- **Reset mid-response:** `rst_n` low during the third DATA packet → all outputs 0 immediately. A subsequent full response yields `res_valid` with correct `result`.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU serial response monitor.
// Holds the packet and response state types, the error-flag bit positions
// and the CRC3 helper used by both the decoder and the bench scoreboard.
package alu_pkg;

    // Packet framing: start + type + 8 payload + stop
    localparam int PKT_BITS      = 11;
    localparam int PKT_DATA_BITS = 10;

    // Payload bit that separates a result trailer (0) from an error packet (1)
    localparam int CTL_KIND_BIT = 7;

    // Bit positions inside err_flags, upper and lower copies as sent by the ALU
    localparam int ERR_DATA_HI = 5;
    localparam int ERR_CRC_HI  = 4;
    localparam int ERR_OP_HI   = 3;
    localparam int ERR_DATA_LO = 2;
    localparam int ERR_CRC_LO  = 1;
    localparam int ERR_OP_LO   = 0;

    typedef enum logic {
        PKT_DATA = 1'b0,
        PKT_CTL  = 1'b1
    } pkt_type_t;

    typedef enum logic [1:0] {
        PK_IDLE  = 2'd0,
        PK_SHIFT = 2'd1,
        PK_CHECK = 2'd2
    } pk_state_t;

    typedef enum logic [1:0] {
        R_WAIT = 2'd0,
        R_DATA = 2'd1,
        R_EMIT = 2'd2
    } resp_state_t;

    // CRC3 over x^3+x+1, zero init, MSB of the vector shifted in first
    function automatic logic [2:0] calc_crc3(input bit [36:0] vec);
        logic [2:0] crc;
        logic       fb;
        crc = 3'b000;
        for (int i = 36; i >= 0; i--) begin
            fb  = crc[2] ^ vec[i];
            crc = {crc[1], crc[0] ^ fb, fb};
        end
        return crc;
    endfunction

endpackage

// File: rtl/alu_pkt_rx.sv
// 11-bit packet deserializer for the ALU sout line.
// Waits for a start bit, shifts in the type, payload and stop bits, then
// spends one check cycle presenting the packet. A start bit seen during
// the check cycle is captured so zero-gap packets are not lost.
module alu_pkt_rx
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sout,
    output logic       pkt_valid,
    output pkt_type_t  pkt_type,
    output logic [7:0] pkt_byte,
    output logic       pkt_stop_err,
    output logic       pkt_busy
);

    pk_state_t                 pk_state;
    logic [PKT_DATA_BITS-1:0]  shift_reg;
    logic [3:0]                bit_cnt;

    // The line is owned by a packet only while bits are being shifted in
    assign pkt_busy = (pk_state == PK_SHIFT);

    // Packet FSM: detect start, shift 10 bits MSB first, then present the packet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pk_state     <= PK_IDLE;
            shift_reg    <= '0;
            bit_cnt      <= 4'd0;
            pkt_valid    <= 1'b0;
            pkt_type     <= PKT_DATA;
            pkt_byte     <= 8'h00;
            pkt_stop_err <= 1'b0;
        end else begin
            pkt_valid    <= 1'b0;
            pkt_stop_err <= 1'b0;
            case (pk_state)
                PK_IDLE: begin
                    if (!sout) begin
                        pk_state <= PK_SHIFT;
                        bit_cnt  <= 4'd9;
                    end
                end
                PK_SHIFT: begin
                    shift_reg <= {shift_reg[PKT_DATA_BITS-2:0], sout};
                    if (bit_cnt == 4'd0) begin
                        pk_state <= PK_CHECK;
                    end else begin
                        bit_cnt <= bit_cnt - 4'd1;
                    end
                end
                PK_CHECK: begin
                    pkt_valid    <= 1'b1;
                    pkt_type     <= pkt_type_t'(shift_reg[9]);
                    pkt_byte     <= shift_reg[8:1];
                    pkt_stop_err <= ~shift_reg[0];
                    if (!sout) begin
                        pk_state <= PK_SHIFT;
                        bit_cnt  <= 4'd9;
                    end else begin
                        pk_state <= PK_IDLE;
                    end
                end
                default: begin
                    pk_state <= PK_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_resp_decoder.sv
// ALU serial response monitor.
// Reassembles packets from alu_pkt_rx into either a 32-bit result with
// flags and CRC status, or a decoded error packet, and flags framing,
// sequence and inter-packet timeout problems on frame_err.
// Build option: define ALU_RESP_CRC_CHECK_EN to compare the received CRC3;
// without it crc_ok simply reads 1 with every decoded result.
module alu_resp_decoder
    import alu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sout,
    output logic        res_valid,
    output logic [31:0] result,
    output logic [3:0]  flags,
    output logic        crc_ok,
    output logic        err_valid,
    output logic [5:0]  err_flags,
    output logic        parity_ok,
    output logic        frame_err
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);

    logic        pkt_valid;
    pkt_type_t   pkt_type;
    logic [7:0]  pkt_byte;
    logic        pkt_stop_err;
    logic        pkt_busy;

    resp_state_t        resp_state;
    logic [2:0]         data_cnt;
    logic [31:0]        data_shift;
    logic [IDLE_W-1:0]  idle_cnt;
    logic               line_idle;
    logic               timeout_hit;
    logic               crc_match;

    alu_pkt_rx u_pkt_rx (
        .clk          (clk),
        .rst_n        (rst_n),
        .sout         (sout),
        .pkt_valid    (pkt_valid),
        .pkt_type     (pkt_type),
        .pkt_byte     (pkt_byte),
        .pkt_stop_err (pkt_stop_err),
        .pkt_busy     (pkt_busy)
    );

    // A cycle is idle when no packet is being shifted and no start bit is on the line
    assign line_idle   = ~pkt_busy & sout;
    assign timeout_hit = (resp_state == R_DATA) && line_idle && (idle_cnt == IDLE_MAX);

`ifdef ALU_RESP_CRC_CHECK_EN
    logic [2:0] crc_calc;

    // CRC3 of the assembled result, a zero pad bit and the trailer's flags
    always_comb begin
        crc_calc  = calc_crc3({data_shift, 1'b0, pkt_byte[6:3]});
        crc_match = (crc_calc == pkt_byte[2:0]);
    end
`else
    // Without the checker every decoded result is reported as CRC-clean
    assign crc_match = 1'b1;
`endif

    // Count consecutive idle cycles between a stop bit and the next start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (!line_idle) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IDLE_MAX) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // Response FSM: collect four data bytes, then finish on a trailer or error packet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_state <= R_WAIT;
            data_cnt   <= 3'd0;
            data_shift <= 32'h0;
            result     <= 32'h0;
            flags      <= 4'h0;
            crc_ok     <= 1'b0;
            err_flags  <= 6'h00;
            parity_ok  <= 1'b0;
            res_valid  <= 1'b0;
            err_valid  <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            err_valid <= 1'b0;
            frame_err <= 1'b0;
            if (pkt_valid) begin
                if (pkt_stop_err) begin
                    frame_err  <= 1'b1;
                    data_cnt   <= 3'd0;
                    resp_state <= R_WAIT;
                end else if (pkt_type == PKT_DATA) begin
                    if (data_cnt == 3'd4) begin
                        frame_err  <= 1'b1;
                        data_cnt   <= 3'd0;
                        resp_state <= R_WAIT;
                    end else begin
                        data_shift <= {data_shift[23:0], pkt_byte};
                        data_cnt   <= data_cnt + 3'd1;
                        resp_state <= R_DATA;
                    end
                end else if (!pkt_byte[CTL_KIND_BIT]) begin
                    if (data_cnt == 3'd4) begin
                        result     <= data_shift;
                        flags      <= pkt_byte[6:3];
                        crc_ok     <= crc_match;
                        res_valid  <= 1'b1;
                        data_cnt   <= 3'd0;
                        resp_state <= R_EMIT;
                    end else begin
                        frame_err  <= 1'b1;
                        data_cnt   <= 3'd0;
                        resp_state <= R_WAIT;
                    end
                end else begin
                    if (data_cnt == 3'd0) begin
                        err_flags  <= pkt_byte[6:1];
                        parity_ok  <= ~^pkt_byte;
                        err_valid  <= 1'b1;
                        resp_state <= R_EMIT;
                    end else begin
                        frame_err  <= 1'b1;
                        data_cnt   <= 3'd0;
                        resp_state <= R_WAIT;
                    end
                end
            end else if (timeout_hit) begin
                frame_err  <= 1'b1;
                data_cnt   <= 3'd0;
                resp_state <= R_WAIT;
            end else if (resp_state == R_EMIT) begin
                resp_state <= R_WAIT;
            end
        end
    end

endmodule

// File: tb/tb_alu_resp_decoder.sv
// Self-checking bench for alu_resp_decoder.
// Drives ALU-style packets on sout, pushes the expected pulse (kind, cycle
// and payload) to a scoreboard queue, and compares it with the pulses the
// DUT produces. Honours ALU_RESP_CRC_CHECK_EN for the crc_ok expectations.
module tb_alu_resp_decoder;

    localparam int K_RES   = 1;
    localparam int K_ERR   = 2;
    localparam int K_FRAME = 3;
    localparam int K_MULTI = 4;

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] result;
        logic [3:0]  flags;
        logic        crc_ok;
        logic [5:0]  err_flags;
        logic        parity_ok;
    } ev_t;

    logic        clk;
    logic        rst_n;
    logic        sout;
    logic        res_valid;
    logic [31:0] result;
    logic [3:0]  flags;
    logic        crc_ok;
    logic        err_valid;
    logic [5:0]  err_flags;
    logic        parity_ok;
    logic        frame_err;

    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    ev_t exp_q[$];
    ev_t obs_q[$];

    alu_resp_decoder #(.TIMEOUT_CYCLES(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sout      (sout),
        .res_valid (res_valid),
        .result    (result),
        .flags     (flags),
        .crc_ok    (crc_ok),
        .err_valid (err_valid),
        .err_flags (err_flags),
        .parity_ok (parity_ok),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every pulse with the number of the edge that raised it
    always @(negedge clk) begin
        ev_t o;
        if (rst_n && (res_valid || err_valid || frame_err)) begin
            if (int'(res_valid) + int'(err_valid) + int'(frame_err) > 1) o.kind = K_MULTI;
            else if (res_valid) o.kind = K_RES;
            else if (err_valid) o.kind = K_ERR;
            else o.kind = K_FRAME;
            o.cyc       = cyc;
            o.result    = result;
            o.flags     = flags;
            o.crc_ok    = crc_ok;
            o.err_flags = err_flags;
            o.parity_ok = parity_ok;
            obs_q.push_back(o);
        end
    end

    // Reference CRC3 by polynomial long division of {C,0,flags} * x^3
    function automatic logic [2:0] ref_crc3(input logic [31:0] c, input logic [3:0] f);
        logic [39:0] r;
        r = {c, 1'b0, f, 3'b000};
        for (int i = 39; i >= 3; i--) begin
            if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
        end
        return r[2:0];
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sout = 1'b1;
        end
    endtask

    // Drive one 11-bit packet; s is the edge that samples its start bit
    task automatic send_packet(input bit ctl, input logic [7:0] b, input bit stop, output int s);
        @(negedge clk);
        sout = 1'b0;
        s = cyc + 1;
        @(negedge clk);
        sout = ctl;
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            sout = b[i];
        end
        @(negedge clk);
        sout = stop;
    endtask

    task automatic send_result(input logic [31:0] c, input logic [3:0] f, input logic [2:0] crc_flip);
        ev_t  e;
        int   s;
        logic [2:0] crc;
        crc = ref_crc3(c, f) ^ crc_flip;
        send_packet(1'b0, c[31:24], 1'b1, s);
        send_packet(1'b0, c[23:16], 1'b1, s);
        send_packet(1'b0, c[15:8],  1'b1, s);
        send_packet(1'b0, c[7:0],   1'b1, s);
        send_packet(1'b1, {1'b0, f, crc}, 1'b1, s);
        e.kind   = K_RES;
        e.cyc    = s + 12;
        e.result = c;
        e.flags  = f;
`ifdef ALU_RESP_CRC_CHECK_EN
        e.crc_ok = (crc_flip == 3'b000);
`else
        e.crc_ok = 1'b1;
`endif
        e.err_flags = '0;
        e.parity_ok = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic send_err(input logic [7:0] payload);
        ev_t e;
        int  s;
        send_packet(1'b1, payload, 1'b1, s);
        e.kind      = K_ERR;
        e.cyc       = s + 12;
        e.result    = '0;
        e.flags     = '0;
        e.crc_ok    = 1'b0;
        e.err_flags = payload[6:1];
        e.parity_ok = ($countones(payload) % 2 == 0);
        exp_q.push_back(e);
    endtask

    task automatic push_frame(input int s);
        ev_t e;
        e.kind = K_FRAME;
        e.cyc  = s;
        e.result = '0; e.flags = '0; e.crc_ok = 1'b0; e.err_flags = '0; e.parity_ok = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic wait_obs(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            #1;
            got = (obs_q.size() > 0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sout  = 1'b1;
        #1;
        checks++;
        if ({res_valid, err_valid, frame_err} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_pulses: got %b, expected 000", {res_valid, err_valid, frame_err});
        end
        checks++;
        if ({result, flags, crc_ok, err_flags, parity_ok} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_held: result %h flags %b crc_ok %b err_flags %b parity_ok %b, expected all 0",
                     result, flags, crc_ok, err_flags, parity_ok);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_result();
        ev_t e, o;
        bit  got;
        send_result(32'h1234_5678, 4'b0000, 3'b000);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_obs(100, got);
            checks++;
            if (!got) begin
                errors++;
                $display("[TB] FAIL result_seen: no pulse, expected kind %0d at cycle %0d", e.kind, e.cyc);
            end else begin
                o = obs_q.pop_front();
                checks++;
                if (o.kind !== e.kind || o.cyc !== e.cyc) begin
                    errors++;
                    $display("[TB] FAIL result_timing: kind %0d cycle %0d, expected kind %0d cycle %0d", o.kind, o.cyc, e.kind, e.cyc);
                end
                checks++;
                if ({o.result, o.flags, o.crc_ok} !== {e.result, e.flags, e.crc_ok}) begin
                    errors++;
                    $display("[TB] FAIL result_data: %h/%b/%b, expected %h/%b/%b", o.result, o.flags, o.crc_ok, e.result, e.flags, e.crc_ok);
                end
            end
        end
        idle(30);
        #1;
        checks++;
        if (obs_q.size() !== 0) begin
            errors++;
            $display("[TB] FAIL result_once: %0d extra pulses, expected 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_crc_corrupt();
        ev_t e, o;
        bit  got;
        send_result(32'h1234_5678, 4'b0000, 3'b001);
        send_result(32'hDEAD_BEEF, 4'b1010, 3'b000);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_obs(100, got);
            checks++;
            if (!got) begin
                errors++;
                $display("[TB] FAIL crc_seen: no pulse, expected kind %0d at cycle %0d", e.kind, e.cyc);
            end else begin
                o = obs_q.pop_front();
                checks++;
                if (o.kind !== e.kind || o.cyc !== e.cyc) begin
                    errors++;
                    $display("[TB] FAIL crc_timing: kind %0d cycle %0d, expected kind %0d cycle %0d", o.kind, o.cyc, e.kind, e.cyc);
                end
                checks++;
                if ({o.result, o.flags, o.crc_ok} !== {e.result, e.flags, e.crc_ok}) begin
                    errors++;
                    $display("[TB] FAIL crc_data: %h/%b/%b, expected %h/%b/%b", o.result, o.flags, o.crc_ok, e.result, e.flags, e.crc_ok);
                end
            end
        end
        idle(5);
    endtask

    task automatic test_error_packet();
        ev_t e, o;
        bit  got;
        send_err(8'hC9);
        send_err(8'hC8);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_obs(100, got);
            checks++;
            if (!got) begin
                errors++;
                $display("[TB] FAIL err_seen: no pulse, expected kind %0d at cycle %0d", e.kind, e.cyc);
            end else begin
                o = obs_q.pop_front();
                checks++;
                if (o.kind !== e.kind || o.cyc !== e.cyc) begin
                    errors++;
                    $display("[TB] FAIL err_timing: kind %0d cycle %0d, expected kind %0d cycle %0d", o.kind, o.cyc, e.kind, e.cyc);
                end
                checks++;
                if ({o.err_flags, o.parity_ok} !== {e.err_flags, e.parity_ok}) begin
                    errors++;
                    $display("[TB] FAIL err_data: flags %b parity_ok %b, expected %b %b", o.err_flags, o.parity_ok, e.err_flags, e.parity_ok);
                end
            end
        end
        checks++;
        if (result !== 32'hDEAD_BEEF) begin
            errors++;
            $display("[TB] FAIL result_hold: result %h, expected deadbeef", result);
        end
        idle(5);
    endtask

    task automatic test_back_to_back();
        ev_t e, o;
        bit  got;
        send_result(32'hCAFE_0001, 4'b0110, 3'b000);
        send_err(8'h81);
        send_err(8'hC9);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_obs(100, got);
            checks++;
            if (!got) begin
                errors++;
                $display("[TB] FAIL b2b_seen: no pulse, expected kind %0d at cycle %0d", e.kind, e.cyc);
            end else begin
                o = obs_q.pop_front();
                checks++;
                if (o.kind !== e.kind || o.cyc !== e.cyc) begin
                    errors++;
                    $display("[TB] FAIL b2b_timing: kind %0d cycle %0d, expected kind %0d cycle %0d", o.kind, o.cyc, e.kind, e.cyc);
                end
                checks++;
                if (e.kind == K_RES ? ({o.result, o.flags, o.crc_ok} !== {e.result, e.flags, e.crc_ok})
                                    : ({o.err_flags, o.parity_ok} !== {e.err_flags, e.parity_ok})) begin
                    errors++;
                    $display("[TB] FAIL b2b_data: %h/%b/%b/%b/%b, expected %h/%b/%b/%b/%b",
                             o.result, o.flags, o.crc_ok, o.err_flags, o.parity_ok,
                             e.result, e.flags, e.crc_ok, e.err_flags, e.parity_ok);
                end
            end
        end
        idle(5);
    endtask

    task automatic test_framing();
        ev_t e, o;
        bit  got;
        int  s;
        // Bad stop bit on the second data packet
        send_packet(1'b0, 8'h11, 1'b1, s);
        send_packet(1'b0, 8'h22, 1'b0, s);
        idle(20);
        push_frame(s + 12);
        // Trailer after only three data packets
        send_packet(1'b0, 8'h01, 1'b1, s);
        send_packet(1'b0, 8'h02, 1'b1, s);
        send_packet(1'b0, 8'h03, 1'b1, s);
        send_packet(1'b1, 8'h05, 1'b1, s);
        push_frame(s + 12);
        idle(5);
        // Fifth data packet where a trailer was due
        for (int i = 0; i < 5; i++) send_packet(1'b0, 8'(i + 8'h40), 1'b1, s);
        push_frame(s + 12);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_obs(100, got);
            checks++;
            if (!got) begin
                errors++;
                $display("[TB] FAIL frame_seen: no pulse, expected frame_err at cycle %0d", e.cyc);
            end else begin
                o = obs_q.pop_front();
                checks++;
                if (o.kind !== e.kind || o.cyc !== e.cyc) begin
                    errors++;
                    $display("[TB] FAIL frame_timing: kind %0d cycle %0d, expected kind %0d cycle %0d", o.kind, o.cyc, e.kind, e.cyc);
                end
            end
        end
        idle(30);
        #1;
        checks++;
        if (obs_q.size() !== 0) begin
            errors++;
            $display("[TB] FAIL frame_no_result: %0d extra pulses, expected 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_timeout();
        ev_t e, o;
        bit  got;
        int  s;
        logic [31:0] c;
        // 64 idle cycles is still within the limit
        c = 32'hA1B2_C3D4;
        send_packet(1'b0, c[31:24], 1'b1, s);
        send_packet(1'b0, c[23:16], 1'b1, s);
        idle(64);
        send_packet(1'b0, c[15:8], 1'b1, s);
        send_packet(1'b0, c[7:0],  1'b1, s);
        send_packet(1'b1, {1'b0, 4'b0011, ref_crc3(c, 4'b0011)}, 1'b1, s);
        e.kind = K_RES; e.cyc = s + 12; e.result = c; e.flags = 4'b0011; e.crc_ok = 1'b1;
        e.err_flags = '0; e.parity_ok = 1'b0;
        exp_q.push_back(e);
        idle(5);
        // 65 idle cycles aborts, then a clean response decodes
        send_packet(1'b0, 8'h77, 1'b1, s);
        send_packet(1'b0, 8'h66, 1'b1, s);
        idle(65);
        push_frame(s + 75);
        send_result(32'h5555_AAAA, 4'b1001, 3'b000);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_obs(100, got);
            checks++;
            if (!got) begin
                errors++;
                $display("[TB] FAIL timeout_seen: no pulse, expected kind %0d at cycle %0d", e.kind, e.cyc);
            end else begin
                o = obs_q.pop_front();
                checks++;
                if (o.kind !== e.kind || o.cyc !== e.cyc) begin
                    errors++;
                    $display("[TB] FAIL timeout_timing: kind %0d cycle %0d, expected kind %0d cycle %0d", o.kind, o.cyc, e.kind, e.cyc);
                end
                checks++;
                if (e.kind == K_RES && {o.result, o.flags, o.crc_ok} !== {e.result, e.flags, e.crc_ok}) begin
                    errors++;
                    $display("[TB] FAIL timeout_data: %h/%b/%b, expected %h/%b/%b", o.result, o.flags, o.crc_ok, e.result, e.flags, e.crc_ok);
                end
            end
        end
        idle(5);
    endtask

    task automatic test_reset_mid();
        ev_t e, o;
        bit  got;
        int  s;
        send_packet(1'b0, 8'h11, 1'b1, s);
        send_packet(1'b0, 8'h22, 1'b1, s);
        @(negedge clk);
        sout = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sout = i[0];
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({res_valid, err_valid, frame_err, result, flags, crc_ok, err_flags, parity_ok} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid: result %h flags %b crc_ok %b err_flags %b parity_ok %b pulses %b, expected all 0",
                     result, flags, crc_ok, err_flags, parity_ok, {res_valid, err_valid, frame_err});
        end
        @(negedge clk);
        sout = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(20);
        #1;
        checks++;
        if (obs_q.size() !== 0) begin
            errors++;
            $display("[TB] FAIL reset_partial: %0d pulses after reset, expected 0", obs_q.size());
            obs_q.delete();
        end
        send_result(32'h0BAD_F00D, 4'b0101, 3'b000);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_obs(100, got);
            checks++;
            if (!got) begin
                errors++;
                $display("[TB] FAIL reset_recover_seen: no pulse, expected result at cycle %0d", e.cyc);
            end else begin
                o = obs_q.pop_front();
                checks++;
                if (o.kind !== e.kind || o.cyc !== e.cyc || {o.result, o.flags, o.crc_ok} !== {e.result, e.flags, e.crc_ok}) begin
                    errors++;
                    $display("[TB] FAIL reset_recover: kind %0d cycle %0d %h/%b/%b, expected kind %0d cycle %0d %h/%b/%b",
                             o.kind, o.cyc, o.result, o.flags, o.crc_ok, e.kind, e.cyc, e.result, e.flags, e.crc_ok);
                end
            end
        end
        idle(5);
    endtask

    initial begin
        test_reset();
        test_result();
        test_crc_corrupt();
        test_error_packet();
        test_back_to_back();
        test_framing();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion before 50000 cycles");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
